// File: rtl/clock_text_gen.sv
// ---------------------------------------------------------------------------
// clock_text_gen
//
// Time-keeping and text-formatting stage of the digital clock. Keeps
// HH:MM:SS in BCD, lets the user set hours and minutes with two debounced
// buttons, and renders two 16-character ASCII lines. The downstream LCD
// writer pulls a coherent copy of both lines through a four-phase
// request/acknowledge handshake.
//
// Ports
//   lcdclk    in   clock
//   resetn    in   asynchronous, active-low reset
//   btn_mode  in   debounced level; rising edge cycles RUN -> SET_H -> SET_M
//   btn_inc   in   debounced level; rising edge increments selected field
//   snap_req  in   snapshot request from the LCD writer (level)
//   snap_ack  out  snapshot acknowledge (level)
//   line1     out  "Time  HH:MM:SS  ", [127:120] is column 0
//   line2     out  mode text padded with spaces, same byte order
// ---------------------------------------------------------------------------
module clock_text_gen #(
    parameter int TICKS_PER_SEC = 50000
) (
    input  logic         lcdclk,
    input  logic         resetn,
    input  logic         btn_mode,
    input  logic         btn_inc,
    input  logic         snap_req,
    output logic         snap_ack,
    output logic [127:0] line1,
    output logic [127:0] line2
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_SET_H = 2'd1;
    localparam logic [1:0] MODE_SET_M = 2'd2;

    // BCD increment of a two-digit value, wrapping to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    hh_q, hh_d;
    logic [7:0]    mm_q, mm_d;
    logic [7:0]    ss_q, ss_d;
    // [0],[1] synchronise the pin; [2] holds the previous synchronised level.
    logic [2:0]    mode_sync_q, mode_sync_d;
    logic [2:0]    inc_sync_q, inc_sync_d;
    logic          snap_ack_q, snap_ack_d;
    logic [127:0]  line1_q, line1_d;
    logic [127:0]  line2_q, line2_d;

    logic          sec_tick;
    logic          mode_pulse;
    logic          inc_pulse;
    logic [127:0]  line1_fmt;
    logic [127:0]  line2_fmt;

    assign mode_pulse = mode_sync_q[1] & ~mode_sync_q[2];
    assign inc_pulse  = inc_sync_q[1] & ~inc_sync_q[2];
    assign sec_tick   = (presc_q == PRESC_MAX) && (mode_q == MODE_RUN);

    // Mode FSM, time counters and prescaler.
    always_comb begin
        mode_d = mode_q;
        hh_d   = hh_q;
        mm_d   = mm_q;
        ss_d   = ss_q;

        case (mode_q)
            MODE_RUN: begin
                if (sec_tick) begin
                    ss_d = bcd_inc(ss_q, 8'h59);
                    if (ss_q == 8'h59) begin
                        mm_d = bcd_inc(mm_q, 8'h59);
                        if (mm_q == 8'h59) begin
                            hh_d = bcd_inc(hh_q, 8'h23);
                        end
                    end
                end
                // Entering SET_H overrides the tick's seconds value; carries stay.
                if (mode_pulse) begin
                    mode_d = MODE_SET_H;
                    ss_d   = 8'h00;
                end
            end
            MODE_SET_H: begin
                if (inc_pulse) begin
                    hh_d = bcd_inc(hh_q, 8'h23);
                end
                if (mode_pulse) begin
                    mode_d = MODE_SET_M;
                end
            end
            MODE_SET_M: begin
                if (inc_pulse) begin
                    mm_d = bcd_inc(mm_q, 8'h59);
                end
                if (mode_pulse) begin
                    mode_d = MODE_RUN;
                end
            end
            default: begin
                mode_d = MODE_RUN;
            end
        endcase

        // Held at 0 outside RUN and on the edge that returns to RUN, so the
        // first second after setting is a full period.
        if (mode_q != MODE_RUN || mode_d != MODE_RUN) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_comb begin
        mode_sync_d = {mode_sync_q[1:0], btn_mode};
        inc_sync_d  = {inc_sync_q[1:0], btn_inc};
    end

    // Text formatting from the current counters and mode.
    always_comb begin
        line1_fmt = {"Time  ",
                     to_ascii(hh_q[7:4]), to_ascii(hh_q[3:0]), 8'h3A,
                     to_ascii(mm_q[7:4]), to_ascii(mm_q[3:0]), 8'h3A,
                     to_ascii(ss_q[7:4]), to_ascii(ss_q[3:0]),
                     8'h20, 8'h20};
        case (mode_q)
            MODE_SET_H: line2_fmt = {"SET HOUR", {8{8'h20}}};
            MODE_SET_M: line2_fmt = {"SET MIN", {9{8'h20}}};
            default:    line2_fmt = {"RUN", {13{8'h20}}};
        endcase
    end

    // Four-phase snapshot handshake; lines only change on the load edge.
    always_comb begin
        snap_ack_d = snap_ack_q;
        line1_d    = line1_q;
        line2_d    = line2_q;
        if (snap_req && !snap_ack_q) begin
            snap_ack_d = 1'b1;
            line1_d    = line1_fmt;
            line2_d    = line2_fmt;
        end else if (!snap_req) begin
            snap_ack_d = 1'b0;
        end
    end

    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            presc_q     <= '0;
            mode_q      <= MODE_RUN;
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            mode_sync_q <= 3'b000;
            inc_sync_q  <= 3'b000;
            snap_ack_q  <= 1'b0;
            line1_q     <= {"Time  00:00:00", 8'h20, 8'h20};
            line2_q     <= {"RUN", {13{8'h20}}};
        end else begin
            presc_q     <= presc_d;
            mode_q      <= mode_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            mode_sync_q <= mode_sync_d;
            inc_sync_q  <= inc_sync_d;
            snap_ack_q  <= snap_ack_d;
            line1_q     <= line1_d;
            line2_q     <= line2_d;
        end
    end

    assign snap_ack = snap_ack_q;
    assign line1    = line1_q;
    assign line2    = line2_q;

endmodule

// File: tb/tb_clock_text_gen.sv
module tb_clock_text_gen;

    logic         lcdclk = 1'b0;
    logic         resetn;
    logic         btn_mode;
    logic         btn_inc;
    logic         snap_req;
    logic         snap_ack;
    logic [127:0] line1;
    logic [127:0] line2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] L1_RESET = 128'h54696D652020_3030_3A_3030_3A_3030_2020;
    localparam logic [127:0] L2_RUN   = 128'h52554E_20202020202020202020202020;
    localparam logic [127:0] L2_SETH  = 128'h5345542048_4F5552_2020202020202020;
    localparam logic [127:0] L2_SETM  = 128'h534554204D494E_202020202020202020;

    clock_text_gen #(.TICKS_PER_SEC(4)) dut (
        .lcdclk   (lcdclk),
        .resetn   (resetn),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .snap_req (snap_req),
        .snap_ack (snap_ack),
        .line1    (line1),
        .line2    (line2)
    );

    always #5 lcdclk = ~lcdclk;

    function automatic logic [7:0] dg(input int d);
        return 8'(48 + d);
    endfunction

    function automatic logic [127:0] mk1(input int h, input int m, input int s);
        return {8'h54, 8'h69, 8'h6D, 8'h65, 8'h20, 8'h20,
                dg(h / 10), dg(h % 10), 8'h3A,
                dg(m / 10), dg(m % 10), 8'h3A,
                dg(s / 10), dg(s % 10), 8'h20, 8'h20};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge lcdclk);
        #1;
    endtask

    // Rising edge acted on at the third edge; returns two edges after that.
    task automatic press(input bit is_mode);
        if (is_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
        step(3);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(2);
    endtask

    task automatic press_n(input bit is_mode, input int n);
        for (int i = 0; i < n; i++) press(is_mode);
    endtask

    // Full handshake: request, check the load, release, check ack drop.
    task automatic snap(input string tag, input logic [127:0] e1, input logic [127:0] e2);
        snap_req = 1'b1;
        step(1);
        check({tag, " ack"}, 128'(snap_ack), 128'd1);
        check({tag, " line1"}, line1, e1);
        check({tag, " line2"}, line2, e2);
        snap_req = 1'b0;
        step(1);
        check({tag, " ack_drop"}, 128'(snap_ack), 128'd0);
    endtask

    initial begin
        resetn   = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        snap_req = 1'b0;

        // Reset values
        #22;
        check("rst ack", 128'(snap_ack), 128'd0);
        check("rst line1", line1, L1_RESET);
        check("rst line2", line2, L2_RUN);
        @(negedge lcdclk);
        resetn = 1'b1;

        // Carry at one minute: 240 cycles = 60 s
        step(240);
        snap("carry", mk1(0, 1, 0), L2_RUN);

        // Set-mode wrap: hh 00 + 25 -> 01, mm 01 + 59 -> 00 without carry
        press(1'b1);
        press_n(1'b0, 25);
        snap("seth", mk1(1, 1, 0), L2_SETH);
        press(1'b1);
        press_n(1'b0, 59);
        snap("setm", mk1(1, 0, 0), L2_SETM);
        press(1'b1);
        snap("back_run", mk1(1, 0, 0), L2_RUN);

        // Set 23:59:00 and roll the whole day over
        press(1'b1);
        press_n(1'b0, 22);
        press(1'b1);
        press_n(1'b0, 59);
        press(1'b1);
        snap("set2359", mk1(23, 59, 0), L2_RUN);
        step(235);
        snap("pre_roll", mk1(23, 59, 59), L2_RUN);
        snap("rollover", mk1(0, 0, 0), L2_RUN);

        // Handshake stability: request held across 3 seconds
        snap_req = 1'b1;
        step(1);
        check("hold ack rise", 128'(snap_ack), 128'd1);
        check("hold line1 load", line1, mk1(0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step(4);
            check("hold ack", 128'(snap_ack), 128'd1);
            check("hold line1", line1, mk1(0, 0, 0));
        end
        snap_req = 1'b0;
        step(1);
        check("hold ack drop", 128'(snap_ack), 128'd0);
        check("hold line1 after drop", line1, mk1(0, 0, 0));
        snap("rereq", mk1(0, 0, 4), L2_RUN);

        // Reset in the middle of a handshake at 00:00:05
        step(1);
        snap_req = 1'b1;
        step(1);
        check("mid ack", 128'(snap_ack), 128'd1);
        check("mid line1", line1, mk1(0, 0, 5));
        #2;
        resetn = 1'b0;
        #1;
        check("mid rst ack", 128'(snap_ack), 128'd0);
        check("mid rst line1", line1, L1_RESET);
        check("mid rst line2", line2, L2_RUN);
        snap_req = 1'b0;
        @(negedge lcdclk);
        resetn = 1'b1;
        snap("post_rst", mk1(0, 0, 0), L2_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
